// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcode encoding, instruction field layout and decoded bundle type
package proc_pkg;

  localparam int OPND_W  = 3;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 6;

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_ADDI  = 4'b0001,
    OP_LOAD  = 4'b0010,
    OP_ADD   = 4'b0011,
    OP_SLR   = 4'b0100,
    OP_AND   = 4'b0101,
    OP_SLL   = 4'b0110,
    OP_NOT   = 4'b0111,
    OP_STORE = 4'b1010,
    OP_SUB   = 4'b1011,
    OP_SLRI  = 4'b1100,
    OP_OR    = 4'b1101,
    OP_SLLI  = 4'b1110,
    OP_XOR   = 4'b1111
  } opcode_e;

  // opcode is kept as raw bits so the two unassigned encodings can still be carried
  typedef struct packed {
    logic [3:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        rs1;
    logic [2:0]        rs2;
    logic [OPND_W-1:0] rs1_val;
    logic [OPND_W-1:0] rs2_val;
    logic [IMM_W-1:0]  imm;
    logic              illegal;
  } decoded_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return op[3:1] == 3'b100;
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file, two async read ports, one write port, r0 fixed at zero
module reg_file #(
  parameter int DATA_W = 3,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // same-cycle write is forwarded so a reader never sees the pre-write value
  function automatic logic [DATA_W-1:0] rd_port(input logic [AW-1:0] a);
    if (a == '0)                return '0;
    if (we_i && waddr_i == a)   return wdata_i;
    return mem_q[a];
  endfunction

  assign rdata1_o = rd_port(raddr1_i);
  assign rdata2_o = rd_port(raddr2_i);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode with operand fetch and 2-entry skid buffer
module decode_stage
  import proc_pkg::*;
#(
  parameter int DATA_W = OPND_W,
  parameter int NREGS  = 8
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic [15:0]       in_instr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              wb_en_i,
  input  logic [2:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [3:0]        out_opcode_o,
  output logic [2:0]        out_rd_o,
  output logic [DATA_W-1:0] out_rs1_val_o,
  output logic [DATA_W-1:0] out_rs2_val_o,
  output logic [5:0]        out_imm_o,
  output logic              out_illegal_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  logic [DATA_W-1:0] rf_rs1, rf_rs2;
  decoded_t          in_dec;
  decoded_t          out_q, out_d, skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              accept, xfer;

  reg_file #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    .we_i     (wb_en_i),
    .waddr_i  (wb_addr_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (in_instr_i[RS1_LSB +: 3]),
    .raddr2_i (in_instr_i[RS2_LSB +: 3]),
    .rdata1_o (rf_rs1),
    .rdata2_o (rf_rs2)
  );

  always_comb begin
    in_dec         = '0;
    in_dec.opcode  = in_instr_i[OPC_LSB +: 4];
    in_dec.rd      = in_instr_i[RD_LSB +: 3];
    in_dec.rs1     = in_instr_i[RS1_LSB +: 3];
    in_dec.rs2     = in_instr_i[RS2_LSB +: 3];
    in_dec.rs1_val = rf_rs1;
    in_dec.rs2_val = rf_rs2;
    in_dec.imm     = in_instr_i[IMM_LSB +: IMM_W];
    in_dec.illegal = is_illegal(in_instr_i[OPC_LSB +: 4]);
  end

  // held entries pick up writebacks that land after their operands were captured
  function automatic decoded_t repair(input decoded_t e, input logic en,
                                      input logic [2:0] a, input logic [DATA_W-1:0] d);
    decoded_t r;
    r = e;
    if (en && a != 3'd0) begin
      if (e.rs1 == a) r.rs1_val = d;
      if (e.rs2 == a) r.rs2_val = d;
    end
    return r;
  endfunction

  assign accept = in_valid_i && !skid_valid_q;
  assign xfer   = out_valid_q && out_ready_i;

  always_comb begin
    out_d        = repair(out_q,  wb_en_i, wb_addr_i, wb_data_i);
    skid_d       = repair(skid_q, wb_en_i, wb_addr_i, wb_data_i);
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (xfer) begin
        out_d        = skid_d;
        skid_valid_d = accept;
        if (accept) skid_d = in_dec;
      end
    end else if (!out_valid_q || xfer) begin
      out_valid_d = accept;
      if (accept) out_d = in_dec;
    end else if (accept) begin
      skid_d       = in_dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready_o    = !skid_valid_q;
  assign out_valid_o   = out_valid_q;
  assign out_opcode_o  = out_q.opcode;
  assign out_rd_o      = out_q.rd;
  assign out_rs1_val_o = out_q.rs1_val;
  assign out_rs2_val_o = out_q.rs2_val;
  assign out_imm_o     = out_q.imm;
  assign out_illegal_o = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [15:0] in_instr;
  logic        in_valid, in_ready;
  logic        wb_en;
  logic [2:0]  wb_addr, wb_data;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd, out_rs1_val, out_rs2_val;
  logic [5:0]  out_imm;
  logic        out_illegal, out_valid, out_ready;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk_i(clk), .arst_ni(arst_n),
    .in_instr_i(in_instr), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .out_opcode_o(out_opcode), .out_rd_o(out_rd),
    .out_rs1_val_o(out_rs1_val), .out_rs2_val_o(out_rs2_val),
    .out_imm_o(out_imm), .out_illegal_o(out_illegal),
    .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [2:0] lo);
    return {op, rd, rs1, rs2, lo};
  endfunction

  task automatic test_reset;
    arst_n = 1'b0; in_instr = '0; in_valid = 0; wb_en = 0; wb_addr = '0; wb_data = '0; out_ready = 0;
    tick; tick;
    checks++;
    if ({out_valid, in_ready, out_opcode, out_rd, out_rs1_val, out_rs2_val, out_imm, out_illegal} !== {1'b0, 1'b1, 20'd0})
      $display("FAIL reset_state got valid=%b ready=%b op=%h rd=%0d v1=%0d v2=%0d imm=%0d ill=%b want 0/1/all zero",
               out_valid, in_ready, out_opcode, out_rd, out_rs1_val, out_rs2_val, out_imm, out_illegal);
    else passed++;
    @(negedge clk); arst_n = 1'b1;
    tick;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL post_reset got valid=%b ready=%b want 0 1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_add;
    wb_en = 1; wb_addr = 3'd1; wb_data = 3'd5; tick;
    wb_addr = 3'd2; wb_data = 3'd3; tick;
    wb_en = 0;
    in_instr = 16'h3650; in_valid = 1; out_ready = 1; tick;
    in_valid = 0;
    checks++;
    if ({out_valid, out_opcode, out_rd, out_rs1_val, out_rs2_val, out_imm, out_illegal} !== {1'b1, 4'b0011, 3'd3, 3'd5, 3'd3, 6'd16, 1'b0})
      $display("FAIL add_bundle got valid=%b op=%b rd=%0d v1=%0d v2=%0d imm=%0d ill=%b want 1 0011 3 5 3 16 0",
               out_valid, out_opcode, out_rd, out_rs1_val, out_rs2_val, out_imm, out_illegal);
    else passed++;
    tick;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL add_drain got valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back;
    out_ready = 0; in_valid = 1;
    in_instr = mk(OP_ADD, 3'd1, 3'd1, 3'd2, 3'd0); tick;
    checks++;
    if ({out_valid, out_rd, in_ready} !== {1'b1, 3'd1, 1'b1}) $display("FAIL bp_first got valid=%b rd=%0d ready=%b want 1 1 1", out_valid, out_rd, in_ready);
    else passed++;
    in_instr = mk(OP_SUB, 3'd2, 3'd1, 3'd2, 3'd0); tick;
    checks++;
    if ({out_valid, out_rd, in_ready} !== {1'b1, 3'd1, 1'b0}) $display("FAIL bp_second got valid=%b rd=%0d ready=%b want 1 1 0", out_valid, out_rd, in_ready);
    else passed++;
    in_instr = mk(OP_XOR, 3'd5, 3'd1, 3'd2, 3'd0); tick;
    checks++;
    if ({out_valid, out_rd, out_opcode, in_ready} !== {1'b1, 3'd1, 4'b0011, 1'b0}) $display("FAIL bp_stall got valid=%b rd=%0d op=%b ready=%b want 1 1 0011 0", out_valid, out_rd, out_opcode, in_ready);
    else passed++;
    out_ready = 1; tick;
    checks++;
    if ({out_valid, out_rd, out_opcode, in_ready} !== {1'b1, 3'd2, 4'b1011, 1'b1}) $display("FAIL bp_skid_out got valid=%b rd=%0d op=%b ready=%b want 1 2 1011 1", out_valid, out_rd, out_opcode, in_ready);
    else passed++;
    tick;
    in_valid = 0;
    checks++;
    if ({out_valid, out_rd, out_opcode} !== {1'b1, 3'd5, 4'b1111}) $display("FAIL bp_third got valid=%b rd=%0d op=%b want 1 5 1111", out_valid, out_rd, out_opcode);
    else passed++;
    tick;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty got valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_bypass;
    out_ready = 1; in_valid = 1;
    wb_en = 1; wb_addr = 3'd4; wb_data = 3'd6;
    in_instr = mk(OP_ADD, 3'd1, 3'd4, 3'd0, 3'd0); tick;
    checks++;
    if ({out_valid, out_rs1_val, out_rs2_val} !== {1'b1, 3'd6, 3'd0}) $display("FAIL bypass_r4 got valid=%b v1=%0d v2=%0d want 1 6 0", out_valid, out_rs1_val, out_rs2_val);
    else passed++;
    wb_addr = 3'd0; wb_data = 3'd5;
    in_instr = mk(OP_ADD, 3'd1, 3'd0, 3'd0, 3'd0); tick;
    checks++;
    if ({out_valid, out_rs1_val, out_rs2_val} !== {1'b1, 3'd0, 3'd0}) $display("FAIL bypass_r0 got valid=%b v1=%0d v2=%0d want 1 0 0", out_valid, out_rs1_val, out_rs2_val);
    else passed++;
    wb_en = 0; in_valid = 0; tick;
  endtask

  task automatic test_repair;
    out_ready = 0; in_valid = 1;
    in_instr = mk(OP_ADD, 3'd6, 3'd1, 3'd2, 3'd0); tick;
    in_valid = 0;
    checks++;
    if ({out_rd, out_rs1_val, out_rs2_val} !== {3'd6, 3'd5, 3'd3}) $display("FAIL repair_before got rd=%0d v1=%0d v2=%0d want 6 5 3", out_rd, out_rs1_val, out_rs2_val);
    else passed++;
    wb_en = 1; wb_addr = 3'd2; wb_data = 3'd7; tick;
    wb_en = 0;
    checks++;
    if ({out_valid, out_opcode, out_rd, out_rs1_val, out_rs2_val, out_imm, out_illegal} !== {1'b1, 4'b0011, 3'd6, 3'd5, 3'd7, 6'd16, 1'b0})
      $display("FAIL repair_after got valid=%b op=%b rd=%0d v1=%0d v2=%0d imm=%0d ill=%b want 1 0011 6 5 7 16 0",
               out_valid, out_opcode, out_rd, out_rs1_val, out_rs2_val, out_imm, out_illegal);
    else passed++;
    out_ready = 1; tick;
  endtask

  task automatic test_illegal;
    logic [15:0] instrs [4];
    logic        want_ill [4];
    instrs[0] = 16'h8123; want_ill[0] = 1'b1;
    instrs[1] = 16'h9FFF; want_ill[1] = 1'b1;
    instrs[2] = 16'h0000; want_ill[2] = 1'b0;
    instrs[3] = 16'hB650; want_ill[3] = 1'b0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_instr = instrs[i]; tick;
      checks++;
      if ({out_valid, out_opcode, out_illegal} !== {1'b1, instrs[i][15:12], want_ill[i]})
        $display("FAIL illegal_%0d got valid=%b op=%b ill=%b want 1 %b %b", i, out_valid, out_opcode, out_illegal, instrs[i][15:12], want_ill[i]);
      else passed++;
    end
    in_valid = 0; tick;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2, v1, v2;
    logic [5:0] imm;
  } exp_t;

  task automatic test_random;
    exp_t       q[$];
    exp_t       e;
    logic [2:0] mreg [8];
    logic [19:0] want, got;
    logic       acc, xfer;
    int         bad = 0;
    @(negedge clk); arst_n = 0;
    @(negedge clk); arst_n = 1;
    in_valid = 0; wb_en = 0; out_ready = 0;
    tick;
    for (int r = 0; r < 8; r++) mreg[r] = '0;
    for (int c = 0; c < 540; c++) begin
      checks++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() != 0)) begin
        bad++;
        $display("FAIL rand_hs cyc=%0d got ready=%b valid=%b want occupancy %0d", c, in_ready, out_valid, q.size());
      end else passed++;
      if (q.size() != 0) begin
        want = {q[0].op, q[0].rd, q[0].v1, q[0].v2, q[0].imm, (q[0].op == 4'd8 || q[0].op == 4'd9)};
        got  = {out_opcode, out_rd, out_rs1_val, out_rs2_val, out_imm, out_illegal};
        checks++;
        if (got !== want) $display("FAIL rand_bundle cyc=%0d got %h want %h", c, got, want);
        else passed++;
      end
      in_valid  = (c < 500) && ($urandom_range(0, 9) < 7);
      in_instr  = 16'($urandom);
      wb_en     = (c < 500) && $urandom_range(0, 1) == 1;
      wb_addr   = 3'($urandom);
      wb_data   = 3'($urandom);
      out_ready = (c >= 500) || ($urandom_range(0, 9) < 6);
      acc  = in_valid && q.size() < 2;
      xfer = q.size() != 0 && out_ready;
      if (xfer) void'(q.pop_front());
      if (wb_en && wb_addr != 0) begin
        mreg[wb_addr] = wb_data;
        foreach (q[i]) begin
          if (q[i].rs1 == wb_addr) q[i].v1 = wb_data;
          if (q[i].rs2 == wb_addr) q[i].v2 = wb_data;
        end
      end
      if (acc) begin
        e.op = in_instr[15:12]; e.rd = in_instr[11:9];
        e.rs1 = in_instr[8:6];  e.rs2 = in_instr[5:3];
        e.v1 = mreg[e.rs1];     e.v2 = mreg[e.rs2];
        e.imm = in_instr[5:0];
        q.push_back(e);
      end
      tick;
    end
    in_valid = 0; wb_en = 0;
    if (bad != 0) $display("rand handshake errors: %0d", bad);
  endtask

  task automatic test_async_reset;
    wb_en = 1; wb_addr = 3'd1; wb_data = 3'd5; out_ready = 0; in_valid = 1;
    in_instr = mk(OP_AND, 3'd1, 3'd1, 3'd1, 3'd0); tick;
    wb_en = 0;
    in_instr = mk(OP_OR, 3'd2, 3'd1, 3'd1, 3'd0); tick;
    in_valid = 0;
    checks++;
    if ({out_valid, in_ready, out_rs1_val} !== {1'b1, 1'b0, 3'd5}) $display("FAIL areset_full got valid=%b ready=%b v1=%0d want 1 0 5", out_valid, in_ready, out_rs1_val);
    else passed++;
    #2 arst_n = 0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL areset_immediate got valid=%b ready=%b want 0 1", out_valid, in_ready);
    else passed++;
    @(negedge clk); arst_n = 1;
    in_valid = 1; out_ready = 1;
    in_instr = mk(OP_ADD, 3'd3, 3'd1, 3'd2, 3'd0); tick;
    in_valid = 0;
    checks++;
    if ({out_valid, out_rs1_val, out_rs2_val} !== {1'b1, 3'd0, 3'd0}) $display("FAIL areset_rf got valid=%b v1=%0d v2=%0d want 1 0 0", out_valid, out_rs1_val, out_rs2_val);
    else passed++;
    tick;
  endtask

  initial begin
    test_reset;
    test_add;
    test_back_to_back;
    test_bypass;
    test_repair;
    test_illegal;
    test_random;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Front-end pipeline stage directly upstream of the execution unit.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them into opcode, rd, rs1, rs2 and imm fields.
- Reads source operands from an internal 8-entry register file that the writeback path updates.
- Presents a registered, decoded bundle to the execution stage over a second valid/ready handshake, with a 2-entry skid buffer for full throughput.

Parameters:
- DATA_W, 3, operand/register width; matches the execution unit's operand width.
- NREGS, 8, register count; fixed by the 3-bit register index.

Ports:
- clk_i  input  1  clock, rising edge
- arst_ni  input  1  asynchronous active-low reset
- in_instr_i  input  16  instruction word: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm
- in_valid_i  input  1  instruction present
- in_ready_o  output  1  stage can accept
- wb_en_i  input  1  register write strobe
- wb_addr_i  input  3  register write index
- wb_data_i  input  DATA_W  register write data
- out_opcode_o  output  4  decoded opcode
- out_rd_o  output  3  destination index
- out_rs1_val_o  output  DATA_W  operand 1 value
- out_rs2_val_o  output  DATA_W  operand 2 value
- out_imm_o  output  6  zero-extended immediate
- out_illegal_o  output  1  opcode 1000 or 1001
- out_valid_o  output  1  bundle valid
- out_ready_i  input  1  execution stage accepts

Behaviour:
- Reset (async assert, sync deassert in the reset tree):
  - All register-file entries = 0.
  - Both skid entries invalid.
  - out_valid_o = 0; all out_* data = 0; in_ready_o = 1.
- Handshakes:
  - Input transfer occurs when in_valid_i && in_ready_o.
  - Output transfer occurs when out_valid_o && out_ready_i.
  - out_* fields must stay stable while out_valid_o=1 && out_ready_i=0.
- Latency: an accepted instruction appears on out_* the next cycle when the pipe is empty.
- Throughput: 1 instruction/cycle under continuous out_ready_i=1.
- Skid buffer (2 entries: output register + skid register):
  - in_ready_o = !skid_valid. in_ready_o is a registered signal with no combinational path from out_ready_i.
  - Accept while output is stalled: the instruction goes to the skid register.
  - On an output transfer while the skid is valid: skid moves to the output register and the skid is freed.
  - If the pipe is full and a transfer and an accept happen in the same cycle: skid → output, new instruction → skid.
- Register file:
  - r0 always reads 0.
  - Writes to r0 are ignored.
  - Writes to other registers take effect at the clock edge when wb_en_i=1.
- Operand read and bypass:
  - Operands are read when an instruction is captured.
  - If wb_en_i targets a nonzero rs1/rs2 in the same cycle, the captured value is wb_data_i (write-through).
- Stale-operand repair:
  - Any held entry (output or skid) whose rs1/rs2 index equals a nonzero wb_addr_i with wb_en_i=1 has its operand value replaced by wb_data_i at that edge.
  - If the entry transfers out in that cycle, the replacement follows it to its new location.
- Immediate: imm = in_instr_i[5:0]. Field [5:3] is also rs2; both are always decoded regardless of opcode.
- Illegal opcodes:
  - Opcodes 1000 and 1001 set out_illegal_o=1.
  - The instruction still flows through and is not dropped.
  - Opcode 0000 is a legal NOP.
- Reset mid-operation: all held instructions are discarded immediately and out_valid_o drops asynchronously.

Decomposition:
- Shared package `proc_pkg` holds:
  - the opcode enum (ADDI=0001, ADD=0011, SUB=1011, AND=0101, OR=1101, XOR=1111, NOT=0111, LOAD=0010, STORE=1010, SLL=0110, SLR=0100, SLLI=1110, SLRI=1100, NOP=0000);
  - instruction field position constants;
  - a `decoded_t` struct (opcode, rd, rs1, rs2, rs1_val, rs2_val, imm, illegal).
- One sub-module, `reg_file`: 8×DATA_W, two async read ports, one write port, r0 hardwired zero, write-through bypass.
- Skid logic stays in `decode_stage`.

Test Plan:
- Reset then wb writes r1=5, r2=3; issue ADD rd=3 rs1=1 rs2=2 (0x3650) with out_ready=1 → next cycle out_valid=1, opcode=0011, rd=3, rs1_val=5, rs2_val=3.
- Hold out_ready=0 and present 3 instructions back-to-back → first two accepted, in_ready=0 on the cycle after the second; raise out_ready → outputs appear in order with no loss or duplication.
- Same-cycle bypass: wb_en=1 writing r4=6 while ADD rs1=4 is accepted → out_rs1_val=6. Then repeat with wb_addr=0 → operand reads 0.
- Stale repair: hold an ADD rs2=2 stalled with out_ready=0, then write r2=7 → held out_rs2_val changes to 7 the next cycle; all other fields unchanged.
- Illegal/NOP: send opcode 1000 → out_illegal=1 and the instruction still passes. Send 0x0000 → out_illegal=0.
- Assert arst_ni low with both entries full → out_valid=0 and in_ready=1 immediately. Reading r1 afterward returns 0.
